// File: rtl/wshb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wshb_arbiter
//  Description : N-master pipelined Wishbone (B4) arbiter and interconnect in
//                front of a single slave. The owner keeps the bus for its whole
//                cyc period. Arbitration is round-robin or fixed priority. An
//                optional watchdog aborts an owner whose strobes go unanswered.
//  Revision    : 1.0 - initial release
// ============================================================================
module wshb_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RR_MODE   = 1,
    parameter int TIMEOUT   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTERS-1:0]            m_cyc,
    input  logic [N_MASTERS-1:0]            m_stb,
    input  logic [N_MASTERS-1:0]            m_we,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_adr,
    input  logic [N_MASTERS*DATA_W-1:0]     m_dat_ms,
    input  logic [N_MASTERS*(DATA_W/8)-1:0] m_sel,
    input  logic [N_MASTERS*3-1:0]          m_cti,
    input  logic [N_MASTERS*2-1:0]          m_bte,
    output logic [N_MASTERS-1:0]            m_ack,
    output logic [N_MASTERS-1:0]            m_err,
    output logic [N_MASTERS-1:0]            m_rty,
    output logic [DATA_W-1:0]               m_dat_sm,
    output logic                            s_cyc,
    output logic                            s_stb,
    output logic                            s_we,
    output logic [ADDR_W-1:0]               s_adr,
    output logic [DATA_W-1:0]               s_dat_ms,
    output logic [DATA_W/8-1:0]             s_sel,
    output logic [2:0]                      s_cti,
    output logic [1:0]                      s_bte,
    input  logic                            s_ack,
    input  logic                            s_err,
    input  logic                            s_rty,
    input  logic [DATA_W-1:0]               s_dat_sm,
    output logic [N_MASTERS-1:0]            grant,
    output logic                            abort
);

    localparam int c_SEL_W = DATA_W / 8;
    localparam int c_IDX_W = $clog2(N_MASTERS);
    localparam int c_WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LIM = c_WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_OWNED = 2'd1;
    localparam logic [1:0] c_ST_ABORT = 2'd2;

    logic [1:0]           r_state;
    logic [c_IDX_W-1:0]   r_owner;
    logic [c_IDX_W-1:0]   r_last;
    logic [c_WD_W-1:0]    r_wd;
    logic [N_MASTERS-1:0] r_grant;

    logic [N_MASTERS-1:0] w_req;
    logic [c_IDX_W-1:0]   w_win;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_found;
    logic [N_MASTERS-1:0] w_win_1h;
    logic                 w_term;
    logic                 w_stall;
    logic                 w_wd_hit;

    // The releasing owner never competes in the handover it causes
    assign w_req    = (r_state == c_ST_IDLE) ? m_cyc : (m_cyc & ~r_grant);
    assign w_win_1h = {{(N_MASTERS-1){1'b0}}, 1'b1} << w_win;
    assign w_term   = s_ack | s_err | s_rty;
    assign w_stall  = (r_state == c_ST_OWNED) && s_stb && !w_term;
    assign w_wd_hit = (TIMEOUT != 0) && (r_wd == c_WD_LIM);

    // Winner: first requester after r_last (round-robin) or lowest index (fixed)
    always_comb begin
        w_win   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= N_MASTERS; k++) begin
                w_idx = c_IDX_W'((int'(r_last) + k) % N_MASTERS);
                if (!w_found && w_req[w_idx]) begin
                    w_win   = w_idx;
                    w_found = 1'b1;
                end
            end
        end else begin
            for (int k = N_MASTERS - 1; k >= 0; k--) begin
                if (w_req[c_IDX_W'(k)]) begin
                    w_win = c_IDX_W'(k);
                end
            end
        end
    end

    // Ownership state machine, round-robin pointer and stall watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_owner <= '0;
            r_last  <= c_IDX_W'(N_MASTERS - 1);
            r_wd    <= '0;
            r_grant <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_wd <= '0;
                    if (|m_cyc) begin
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_grant <= w_win_1h;
                        r_state <= c_ST_OWNED;
                    end
                end
                c_ST_OWNED, c_ST_ABORT: begin
                    if (!m_cyc[r_owner]) begin
                        // Release: hand over directly or fall back to idle
                        r_wd <= '0;
                        if (|w_req) begin
                            r_owner <= w_win;
                            r_last  <= w_win;
                            r_grant <= w_win_1h;
                            r_state <= c_ST_OWNED;
                        end else begin
                            r_grant <= '0;
                            r_state <= c_ST_IDLE;
                        end
                    end else if (r_state == c_ST_OWNED) begin
                        if (w_stall && w_wd_hit) begin
                            r_wd    <= '0;
                            r_state <= c_ST_ABORT;
                        end else if (w_stall && (TIMEOUT != 0)) begin
                            r_wd <= r_wd + 1'b1;
                        end else if (w_term) begin
                            r_wd <= '0;
                        end
                    end
                end
                default: begin
                    r_wd    <= '0;
                    r_grant <= '0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Owner pass-through while OWNED; error-terminate pending strobes in ABORT
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        s_cti    = '0;
        s_bte    = '0;
        m_ack    = '0;
        m_err    = '0;
        m_rty    = '0;
        if (r_state == c_ST_OWNED) begin
            s_cyc          = m_cyc[r_owner];
            s_stb          = m_stb[r_owner];
            s_we           = m_we[r_owner];
            s_adr          = m_adr[r_owner*ADDR_W +: ADDR_W];
            s_dat_ms       = m_dat_ms[r_owner*DATA_W +: DATA_W];
            s_sel          = m_sel[r_owner*c_SEL_W +: c_SEL_W];
            s_cti          = m_cti[r_owner*3 +: 3];
            s_bte          = m_bte[r_owner*2 +: 2];
            m_ack[r_owner] = s_ack;
            m_err[r_owner] = s_err;
            m_rty[r_owner] = s_rty;
        end else if (r_state == c_ST_ABORT) begin
            m_err[r_owner] = m_stb[r_owner];
        end
    end

    assign m_dat_sm = s_dat_sm;
    assign grant    = r_grant;
    assign abort    = (r_state == c_ST_ABORT);

endmodule
`default_nettype wire

// File: tb/tb_wshb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wshb_arbiter
//  Description : Bench for wshb_arbiter. Two N=3 instances share stimulus:
//                instance 0 round-robin with TIMEOUT=16, instance 1 fixed
//                priority with TIMEOUT=4. A transaction-level model predicts
//                every output each cycle; directed scenarios add targeted checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wshb_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  m_cyc, m_stb, m_we;
    logic [95:0] m_adr, m_dat_ms;
    logic [11:0] m_sel;
    logic [8:0]  m_cti;
    logic [5:0]  m_bte;
    logic        s_ack, s_err, s_rty;
    logic [31:0] s_dat_sm;

    logic [1:0]        s_cyc, s_stb, s_we, abort;
    logic [1:0][31:0]  s_adr, s_dat_ms, m_dat_sm;
    logic [1:0][3:0]   s_sel;
    logic [1:0][2:0]   s_cti, m_ack, m_err, m_rty, grant;
    logic [1:0][1:0]   s_bte;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wshb_arbiter #(
            .N_MASTERS(3), .ADDR_W(32), .DATA_W(32),
            .RR_MODE((g == 0) ? 1 : 0), .TIMEOUT((g == 0) ? 16 : 4)
        ) u_dut (
            .clk(clk), .rst(rst),
            .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
            .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
            .m_ack(m_ack[g]), .m_err(m_err[g]), .m_rty(m_rty[g]), .m_dat_sm(m_dat_sm[g]),
            .s_cyc(s_cyc[g]), .s_stb(s_stb[g]), .s_we(s_we[g]), .s_adr(s_adr[g]),
            .s_dat_ms(s_dat_ms[g]), .s_sel(s_sel[g]), .s_cti(s_cti[g]), .s_bte(s_bte[g]),
            .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
            .grant(grant[g]), .abort(abort[g])
        );
    end

    // ---------------- reference model (per instance) ----------------
    int  md_own[2];   // owning master, -1 when the bus is free
    int  md_last[2];  // last granted master
    int  md_wd[2];    // consecutive unanswered strobe cycles of the owner
    bit  md_abt[2];
    bit  md_valid = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0][2:0] smp_grant, smp_mack, smp_merr;
    logic [1:0]      smp_abort, smp_scyc, smp_sstb;

    function automatic int rr_of(int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic int to_of(int i);
        return (i == 0) ? 16 : 4;
    endfunction

    function automatic int pick(int i, logic [2:0] req);
        int cand;
        if (rr_of(i) != 0) begin
            for (int k = 1; k <= N; k++) begin
                cand = (md_last[i] + k) % N;
                if (req[cand]) return cand;
            end
        end else begin
            for (int k = 0; k < N; k++) if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int o;
            logic [75:0] exp_s;
            logic [8:0]  exp_t;
            logic [2:0]  exp_g;
            o     = md_own[i];
            exp_s = '0;
            exp_t = '0;
            exp_g = '0;
            if (o >= 0) begin
                exp_g = 3'b001 << o;
                if (!md_abt[i]) begin
                    exp_s = {m_cyc[o], m_stb[o], m_we[o], m_adr[o*32 +: 32], m_dat_ms[o*32 +: 32],
                             m_sel[o*4 +: 4], m_cti[o*3 +: 3], m_bte[o*2 +: 2]};
                    exp_t = {3'(s_ack) << o, 3'(s_err) << o, 3'(s_rty) << o};
                end else begin
                    exp_t = {3'b000, 3'(m_stb[o]) << o, 3'b000};
                end
            end
            chk($sformatf("grant%0d", i), 128'(grant[i]), 128'(exp_g));
            chk($sformatf("abort%0d", i), 128'(abort[i]), 128'(md_abt[i]));
            chk($sformatf("slave_side%0d", i),
                128'({s_cyc[i], s_stb[i], s_we[i], s_adr[i], s_dat_ms[i], s_sel[i], s_cti[i], s_bte[i]}),
                128'(exp_s));
            chk($sformatf("terms%0d", i), 128'({m_ack[i], m_err[i], m_rty[i]}), 128'(exp_t));
            chk($sformatf("rdata%0d", i), 128'(m_dat_sm[i]), 128'(s_dat_sm));
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int o;
            logic [2:0] req;
            o = md_own[i];
            if (rst) begin
                md_own[i] = -1; md_abt[i] = 1'b0; md_last[i] = N - 1; md_wd[i] = 0;
            end else if (o < 0) begin
                if (m_cyc != 3'b000) begin
                    md_own[i] = pick(i, m_cyc); md_last[i] = md_own[i]; md_wd[i] = 0;
                end
            end else if (!m_cyc[o]) begin
                req = m_cyc;
                req[o] = 1'b0;
                md_abt[i] = 1'b0;
                md_wd[i]  = 0;
                if (req != 3'b000) begin
                    md_own[i] = pick(i, req); md_last[i] = md_own[i];
                end else begin
                    md_own[i] = -1;
                end
            end else if (!md_abt[i]) begin
                if (s_ack || s_err || s_rty) md_wd[i] = 0;
                else if (m_stb[o]) begin
                    if (md_wd[i] + 1 >= to_of(i)) begin
                        md_abt[i] = 1'b1; md_wd[i] = 0;
                    end else begin
                        md_wd[i]++;
                    end
                end
            end
        end
        if (rst) md_valid = 1'b1;
    endtask

    // One clock cycle: sample and check at negedge, advance model, move past edge
    task automatic step();
        @(negedge clk);
        smp_grant = grant;  smp_mack = m_ack;  smp_merr = m_err;
        smp_abort = abort;  smp_scyc = s_cyc;  smp_sstb = s_stb;
        if (md_valid) check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int rem[3];
    task automatic rand_inputs();
        for (int i = 0; i < 3; i++) begin
            if (rem[i] == 0 && $urandom_range(3, 0) == 0) rem[i] = int'($urandom_range(8, 1));
            m_cyc[i] = (rem[i] > 0);
            if (rem[i] > 0) rem[i]--;
            m_stb[i] = 1'($urandom);
            m_we[i]  = 1'($urandom);
        end
        m_adr    = {$urandom, $urandom, $urandom};
        m_dat_ms = {$urandom, $urandom, $urandom};
        m_sel    = 12'($urandom);
        m_cti    = 9'($urandom);
        m_bte    = 6'($urandom);
        s_ack    = ($urandom_range(2, 0) == 0);
        s_err    = ($urandom_range(15, 0) == 0);
        s_rty    = ($urandom_range(15, 0) == 0);
        s_dat_sm = $urandom;
        rst      = ($urandom_range(99, 0) == 0);
    endtask

    int ack1, ackx, held, n_rec, gaps, acks;
    logic [2:0] prev;
    logic [2:0] rec[6];
    logic [2:0] rr_exp[6];
    bit abt_seen;

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rem    = '{0, 0, 0};
        idle_inputs();
        m_adr    = {32'h3000_0003, 32'h2000_0002, 32'h1000_0001};
        m_dat_ms = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        m_sel    = 12'hFFF;
        m_cti    = '0;
        m_bte    = '0;
        s_dat_sm = 32'h5A5A_0000;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        step();
        chk("reset_grant", 128'(smp_grant), 128'(0));
        chk("reset_scyc", 128'(smp_scyc), 128'(0));

        // Single master m1, 4-beat read with acks every cycle
        m_cyc = 3'b010; m_stb = 3'b010; s_ack = 1'b1;
        m_cti = {3'b000, 3'b010, 3'b000};
        step();
        chk("s1_idle_grant", 128'(smp_grant[0]), 128'(0));
        ack1 = 0; ackx = 0;
        for (int b = 0; b < 4; b++) begin
            m_cti[5:3] = (b == 3) ? 3'b111 : 3'b010;
            s_dat_sm   = 32'h5A5A_0000 + 32'(b);
            step();
            if (b == 0) chk("s1_grant", 128'(smp_grant[0]), 128'(3'b010));
            ack1 += int'(smp_mack[0][1]);
            ackx += int'(smp_mack[0][0]) + int'(smp_mack[0][2]);
        end
        idle_inputs();
        step();
        chk("s1_ack_count", 128'(ack1), 128'(4));
        chk("s1_other_acks", 128'(ackx), 128'(0));

        // Round-robin fairness with back-to-back 2-cycle transactions
        do_reset();
        m_stb = 3'b111; s_ack = 1'b1;
        held = 0; n_rec = 0; gaps = 0; prev = '0;
        for (int c = 0; c < 40 && n_rec < 6; c++) begin
            m_cyc = 3'b111;
            if (held == 2 && md_own[0] >= 0) m_cyc[md_own[0]] = 1'b0;
            step();
            if (smp_grant[0] != 3'b000 && smp_grant[0] != prev) begin
                rec[n_rec] = smp_grant[0];
                n_rec++;
                held = 1;
            end else if (smp_grant[0] != 3'b000) begin
                held++;
            end
            if (n_rec > 0 && n_rec < 6 && !smp_scyc[0]) gaps++;
            prev = smp_grant[0];
        end
        chk("rr_grants", 128'(n_rec), 128'(6));
        for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), 128'(rec[k]), 128'(rr_exp[k]));
        chk("rr_gaps", 128'(gaps), 128'(5));
        idle_inputs();
        step();

        // Fixed priority: m2 keeps the bus, then m0, then m1
        do_reset();
        m_cyc = 3'b100; m_stb = 3'b100; s_ack = 1'b1;
        step();
        m_cyc = 3'b111; m_stb = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("fp_hold%0d", k), 128'(smp_grant[1]), 128'(3'b100));
        end
        m_cyc = 3'b011;
        step();
        step();
        chk("fp_next_m0", 128'(smp_grant[1]), 128'(3'b001));
        m_cyc = 3'b010;
        step();
        step();
        chk("fp_next_m1", 128'(smp_grant[1]), 128'(3'b010));
        idle_inputs();
        step();

        // Watchdog on the round-robin instance (TIMEOUT=16)
        do_reset();
        m_cyc = 3'b001; m_stb = 3'b001;
        step();
        m_cyc = 3'b011; m_stb = 3'b011;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("wd_quiet%0d", k), 128'(smp_abort[0]), 128'(0));
        end
        step();
        chk("wd_abort", 128'(smp_abort[0]), 128'(1));
        chk("wd_err", 128'(smp_merr[0]), 128'(3'b001));
        chk("wd_scyc", 128'(smp_scyc[0]), 128'(0));
        m_cyc = 3'b010;
        step();
        step();
        chk("wd_handover", 128'(smp_grant[0]), 128'(3'b010));
        idle_inputs();
        step();

        // Reset in the middle of a write burst
        m_cyc = 3'b001; m_stb = 3'b001; m_we = 3'b001; s_ack = 1'b1;
        step();
        step();
        rst = 1'b1; m_cyc = 3'b011;
        step();
        rst = 1'b0;
        step();
        chk("rst_scyc", 128'(smp_scyc), 128'(0));
        chk("rst_sstb", 128'(smp_sstb), 128'(0));
        chk("rst_grant", 128'(smp_grant), 128'(0));
        step();
        chk("rst_first_rr", 128'(smp_grant[0]), 128'(3'b001));
        chk("rst_first_fp", 128'(smp_grant[1]), 128'(3'b001));
        idle_inputs();
        step();
        step();

        // Back-pressure: 3 wait cycles per beat against TIMEOUT=4
        do_reset();
        m_cyc = 3'b001; m_stb = 3'b001;
        step();
        acks = 0; abt_seen = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int w = 0; w < 4; w++) begin
                s_ack    = (w == 3);
                s_dat_sm = $urandom;
                step();
                acks += int'(smp_mack[1][0]);
                abt_seen = abt_seen | smp_abort[1];
            end
        end
        idle_inputs();
        step();
        chk("bp_acks", 128'(acks), 128'(3));
        chk("bp_no_abort", 128'(abt_seen), 128'(0));

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rand_inputs();
            step();
        end
        rst = 1'b0;
        idle_inputs();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
